// File: rtl/sys_bus_dma_if.sv
// sys_bus_dma_if: picorv32-style native memory bus (valid/ready handshake).
// The master modport is the requester side; the slave modport is the responder.
interface sys_bus_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sys_bus_dma.sv
// sys_bus_dma: word-copy DMA engine acting as a second initiator on the native bus.
// Define SYS_BUS_DMA_TIMEOUT_EN to abandon requests not acknowledged within TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for start
// RD    | read request on source pointer, held until mem_ready
// WGAP  | one idle bus cycle so the responder's ack logic re-arms
// WR    | write request on destination pointer, held until mem_ready
// NEXT  | advance pointers, decrement count, check for end or abort
// FIN   | final cycle; done/busy update on the following edge
module sys_bus_dma #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] words_left,
  sys_bus_dma_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WGAP = 3'd2,
    S_WR   = 3'd3,
    S_NEXT = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [31:0]          r_data;
  logic [CNT_WIDTH-1:0] r_words_left;
  logic [CNT_WIDTH-1:0] w_words_dec;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_abort;
  logic                 w_timeout;

  assign w_words_dec = r_words_left - CNT_WIDTH'(1);
  assign busy        = r_busy;
  assign done        = r_done;
  assign words_left  = r_words_left;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (word_count == '0) ? S_FIN : S_RD;
      S_RD: begin
        if (w_timeout)          w_state_nxt = S_FIN;
        else if (bus.mem_ready) w_state_nxt = S_WGAP;
      end
      S_WGAP: w_state_nxt = S_WR;
      S_WR: begin
        if (w_timeout)          w_state_nxt = S_FIN;
        else if (bus.mem_ready) w_state_nxt = S_NEXT;
      end
      // abort may have been latched earlier in the word or be live right now
      S_NEXT: w_state_nxt = (w_words_dec == '0 || r_abort || abort) ? S_FIN : S_RD;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops mem_valid without a clock
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    case (r_state)
      S_RD: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = r_src;
      end
      S_WR: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = r_dst;
        bus.mem_wdata = r_data;
        bus.mem_wstrb = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_src        <= 32'h0;
      r_dst        <= 32'h0;
      r_data       <= 32'h0;
      r_words_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src        <= src_addr & 32'hFFFF_FFFC;
            r_dst        <= dst_addr & 32'hFFFF_FFFC;
            r_words_left <= word_count;
            r_busy       <= 1'b1;
            r_abort      <= abort;
          end
        end
        S_RD: begin
          if (bus.mem_ready) r_data <= bus.mem_rdata;
          if (abort)         r_abort <= 1'b1;
        end
        S_WGAP, S_WR: begin
          if (abort) r_abort <= 1'b1;
        end
        S_NEXT: begin
          r_src        <= r_src + 32'd4;
          r_dst        <= r_dst + 32'd4;
          r_words_left <= w_words_dec;
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SYS_BUS_DMA_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_error;
  logic             w_in_req;
  logic             w_req_entry;

  assign w_in_req    = (r_state == S_RD) || (r_state == S_WR);
  assign w_req_entry = ((w_state_nxt == S_RD) || (w_state_nxt == S_WR)) && (w_state_nxt != r_state);
  assign w_timeout   = w_in_req && !bus.mem_ready && (r_tmo_cnt == '0);
  assign error       = r_error;

  // Down-counter reloaded on every request entry; terminal count is zero
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_tmo_cnt <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_req_entry)                        r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if (w_in_req && r_tmo_cnt != '0)   r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
      if (r_state == S_IDLE && start) r_error <= 1'b0;
      else if (w_timeout)             r_error <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

endmodule
